// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered MSB-first one-hot decoder.
package decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Counter width for a 0..div-1 prescaler; never narrower than one bit.
  function automatic int presc_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  // Code 0 lights the top bit of an out_w-wide word. Bits above out_w are don't-care.
  function automatic logic [63:0] onehot_msb(input int code, input int out_w,
                                             input logic active_low);
    logic [63:0] w;
    w = 64'd1 << (out_w - 1 - code);
    return active_low ? ~w : w;
  endfunction

endpackage

// File: rtl/decoder_scan_prescaler.sv
// Free-running 0..DIV-1 step counter; tc flags the last count of a dwell.
module scan_prescaler
  import decoder_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tc
);

  localparam int CW = presc_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (run) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a direct mode and a
// self-stepping scan mode for display multiplexing.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DIV        = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      in,
  output logic [(1<<SEL_W)-1:0] f,
  output logic [SEL_W-1:0]      code,
  output logic                  step,
  output logic                  wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] BLANK = ACTIVE_LOW ? '1 : '0;

  logic             scan, tc, run, clear;
  logic [SEL_W-1:0] code_q, code_d;
  logic [OUT_W-1:0] f_q, f_d;
  logic             step_q, step_d, wrap_q, wrap_d;
  logic [63:0]      dec;

  assign scan  = (mode_e'(mode) == MODE_SCAN);
  assign run   = en && scan && !load;
  // Direct mode pins the prescaler at 0 so a switch to scan starts a fresh dwell.
  assign clear = en && (!scan || load);

  scan_prescaler #(.DIV(DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clear(clear),
    .tc   (tc)
  );

  always_comb begin
    code_d = code_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (en) begin
      if (!scan || load) begin
        code_d = in;
      end else if (tc) begin
        code_d = code_q + 1'b1;
        step_d = 1'b1;
        wrap_d = (code_q == '1);
      end
    end
  end

  assign dec = onehot_msb(int'(code_d), OUT_W, ACTIVE_LOW);
  assign f_d = en ? dec[OUT_W-1:0] : BLANK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      f_q    <= BLANK;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      code_q <= code_d;
      f_q    <= f_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign f    = f_q;
  assign code = code_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench: active-high and active-low decoders share one stimulus.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [2:0] in;
  logic [7:0] f0, f1;
  logic [2:0] code0, code1;
  logic       step0, step1, wrap0, wrap1;
  int         errs = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .DIV(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(in),
    .f(f0), .code(code0), .step(step0), .wrap(wrap0));

  decoder_scan #(.SEL_W(3), .DIV(4), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(in),
    .f(f1), .code(code1), .step(step1), .wrap(wrap1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; in = 3'd0;
    #2;
    checks++; if (f0 !== 8'h00) begin errs++; $display("FAIL reset_f got %h want 00", f0); end
    checks++; if (f1 !== 8'hFF) begin errs++; $display("FAIL reset_f_al got %h want ff", f1); end
    checks++; if (code0 !== 3'd0) begin errs++; $display("FAIL reset_code got %0d want 0", code0); end
    checks++; if ({step0, wrap0} !== 2'b00) begin errs++; $display("FAIL reset_stepwrap got %b want 00", {step0, wrap0}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0; in = 3'd3;
    tick();
    checks++; if (f0 !== 8'b0001_0000) begin errs++; $display("FAIL direct3_f got %b want 00010000", f0); end
    checks++; if (code0 !== 3'd3) begin errs++; $display("FAIL direct3_code got %0d want 3", code0); end
    in = 3'd7; load = 1'b1;
    tick();
    load = 1'b0;
    checks++; if (f0 !== 8'b0000_0001) begin errs++; $display("FAIL direct7_f got %b want 00000001", f0); end
    checks++; if (code0 !== 3'd7) begin errs++; $display("FAIL direct7_code got %0d want 7", code0); end
  endtask

  task automatic test_scan_sweep();
    int wraps = 0;
    logic [2:0] ec;
    mode = 1'b1; load = 1'b1; in = 3'd0;
    tick();
    load = 1'b0;
    checks++; if (code0 !== 3'd0 || f0 !== 8'h80 || step0 !== 1'b0) begin
      errs++; $display("FAIL scan_start got code=%0d f=%h step=%b want 0 80 0", code0, f0, step0); end
    for (int k = 1; k <= 32; k++) begin
      tick();
      ec = 3'((k / 4) % 8);
      if (wrap0) wraps++;
      checks++; if (code0 !== ec || f0 !== (8'h80 >> ec)) begin
        errs++; $display("FAIL scan_code k=%0d got code=%0d f=%h want %0d %h", k, code0, f0, ec, 8'h80 >> ec); end
      checks++; if (step0 !== (k % 4 == 0) || wrap0 !== (k == 32)) begin
        errs++; $display("FAIL scan_pulse k=%0d got step=%b wrap=%b want %b %b", k, step0, wrap0, k % 4 == 0, k == 32); end
    end
    checks++; if (wraps != 1) begin errs++; $display("FAIL scan_wrapcount got %0d want 1", wraps); end
  endtask

  task automatic test_load_at_tc();
    // Prescaler is 0 after the sweep; three ticks bring it to terminal count.
    repeat (3) tick();
    load = 1'b1; in = 3'd5;
    tick();
    load = 1'b0;
    checks++; if (code0 !== 3'd5 || step0 !== 1'b0 || f0 !== 8'b0000_0100) begin
      errs++; $display("FAIL load_tc got code=%0d step=%b f=%b want 5 0 00000100", code0, step0, f0); end
    repeat (3) tick();
    checks++; if (code0 !== 3'd5) begin errs++; $display("FAIL load_dwell got %0d want 5", code0); end
    tick();
    checks++; if (code0 !== 3'd6 || step0 !== 1'b1) begin
      errs++; $display("FAIL load_next got code=%0d step=%b want 6 1", code0, step0); end
  endtask

  task automatic test_enable_hold();
    load = 1'b1; in = 3'd2;
    tick();
    load = 1'b0;
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (f0 !== 8'h00 || f1 !== 8'hFF || code0 !== 3'd2 || step0 !== 1'b0) begin
        errs++; $display("FAIL en_hold k=%0d got f=%h fal=%h code=%0d step=%b want 00 ff 2 0", k, f0, f1, code0, step0); end
    end
    en = 1'b1;
    repeat (2) tick();
    checks++; if (code0 !== 3'd2 || f0 !== 8'b0010_0000) begin
      errs++; $display("FAIL en_resume got code=%0d f=%b want 2 00100000", code0, f0); end
    tick();
    checks++; if (code0 !== 3'd3 || step0 !== 1'b1) begin
      errs++; $display("FAIL en_advance got code=%0d step=%b want 3 1", code0, step0); end
  endtask

  task automatic test_active_low();
    mode = 1'b0; in = 3'd0;
    tick();
    checks++; if (f1 !== 8'b0111_1111) begin errs++; $display("FAIL al_direct got %b want 01111111", f1); end
    checks++; if (f0 !== 8'b1000_0000) begin errs++; $display("FAIL ah_direct got %b want 10000000", f0); end
    en = 1'b0;
    tick();
    checks++; if (f1 !== 8'hFF || code1 !== 3'd0) begin
      errs++; $display("FAIL al_blank got f=%b code=%0d want 11111111 0", f1, code1); end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    mode = 1'b1; load = 1'b1; in = 3'd6;
    tick();
    load = 1'b0;
    tick();
    checks++; if (code0 !== 3'd6) begin errs++; $display("FAIL prereset_code got %0d want 6", code0); end
    #3 rst = 1'b1;
    #1;
    checks++; if (f0 !== 8'h00 || f1 !== 8'hFF || code0 !== 3'd0 || {step0, wrap0} !== 2'b00) begin
      errs++; $display("FAIL async_rst got f=%h fal=%h code=%0d sw=%b want 00 ff 0 00", f0, f1, code0, {step0, wrap0}); end
    #1 rst = 1'b0;
    tick();
    checks++; if (code0 !== 3'd0 || f0 !== 8'h80 || step0 !== 1'b0) begin
      errs++; $display("FAIL cold_first got code=%0d f=%h step=%b want 0 80 0", code0, f0, step0); end
    repeat (3) tick();
    checks++; if (code0 !== 3'd1 || step0 !== 1'b1) begin
      errs++; $display("FAIL cold_step got code=%0d step=%b want 1 1", code0, step0); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_sweep();
    test_load_at_tc();
    test_enable_hold();
    test_active_low();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
